// File: rtl/shift_split.sv
// Bit-stream unpacker: appends 64-bit packed words MSB-first into a 128-bit buffer and serves 1..64-bit chunks.
// Optional feature macro SPLIT_ZERO_PAD_EN: serve an over-long final request zero-padded instead of rejecting it.
module shift_split #(
    parameter int WORD_W = 64,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_rdy,
    input  logic              msg_fin,
    input  logic [CNT_W-1:0]  last_bits,
    input  logic              req_valid,
    input  logic [CNT_W-1:0]  req_bits,
    output logic              req_rdy,
    input  logic              stall,
    output logic [WORD_W-1:0] data_out,
    output logic              out_valid,
    output logic              error,
    output logic              done
);

    localparam int BUF_W = 2 * WORD_W;

    logic [BUF_W-1:0]  buffer_q, buffer_d;
    logic [7:0]        fill_q, fill_d;
    logic              finSeen_q, finSeen_d;
    logic [WORD_W-1:0] dataOut_q, dataOut_d;
    logic              outValid_q, outValid_d;
    logic              error_q, error_d;
    logic              done_q, done_d;

    logic [7:0]        reqExt;
    logic              lenOk;
    logic              fitOk;
    logic              padOk;
    logic              serve;
    logic              reject;
    logic              accept;
    logic [7:0]        appendLen;
    logic [WORD_W-1:0] wordMask;
    logic [BUF_W-1:0]  shifted;
    logic [BUF_W-1:0]  appended;
    logic [BUF_W-1:0]  chunk;
    logic [7:0]        fillShifted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer_q   <= '0;
            fill_q     <= '0;
            finSeen_q  <= 1'b0;
            dataOut_q  <= '0;
            outValid_q <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            buffer_q   <= buffer_d;
            fill_q     <= fill_d;
            finSeen_q  <= finSeen_d;
            dataOut_q  <= dataOut_d;
            outValid_q <= outValid_d;
            error_q    <= error_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        reqExt = {1'b0, req_bits};
        lenOk  = (reqExt != 8'd0) && (reqExt <= 8'd64);
        fitOk  = (fill_q >= reqExt);
`ifdef SPLIT_ZERO_PAD_EN
        padOk  = finSeen_q && (fill_q != 8'd0);
`else
        padOk  = 1'b0;
`endif
        req_rdy = !stall && lenOk && (fitOk || padOk);
        serve   = req_valid && req_rdy;
        reject  = req_valid && !stall && (!lenOk || (finSeen_q && !fitOk && !padOk));

        in_rdy = (fill_q <= 8'd64) && !finSeen_q;
        accept = in_valid && in_rdy;

        appendLen = 8'd64;
        if (msg_fin && (last_bits != '0)) begin
            appendLen = {1'b0, last_bits};
        end
        // Invalid tail bits of a final word are cleared so the unused buffer region stays zero (gives padding for free).
        wordMask = ~({WORD_W{1'b1}} >> appendLen);

        chunk       = buffer_q >> (8'd128 - reqExt);
        shifted     = buffer_q;
        fillShifted = fill_q;
        if (serve) begin
            shifted     = buffer_q << reqExt;
            fillShifted = fitOk ? (fill_q - reqExt) : 8'd0;
        end

        appended = {data_in & wordMask, {WORD_W{1'b0}}} >> fillShifted;
        buffer_d = shifted;
        fill_d   = fillShifted;
        if (accept) begin
            buffer_d = shifted | appended;
            fill_d   = fillShifted + appendLen;
        end

        done_d    = finSeen_q && serve && (fillShifted == 8'd0);
        finSeen_d = finSeen_q;
        if (accept && msg_fin) begin
            finSeen_d = 1'b1;
        end else if (done_d) begin
            finSeen_d = 1'b0;
        end

        dataOut_d  = serve ? chunk[WORD_W-1:0] : dataOut_q;
        outValid_d = serve;
        error_d    = reject;
    end

    assign data_out  = dataOut_q;
    assign out_valid = outValid_q;
    assign error     = error_q;
    assign done      = done_q;

endmodule

// File: tb/tb_shift_split.sv
// Directed self-checking bench for shift_split; expectations are hand-computed from the stream layout.
module tb_shift_split;

    logic        clk;
    logic        rst;
    logic [63:0] data_in;
    logic        in_valid;
    logic        in_rdy;
    logic        msg_fin;
    logic [6:0]  last_bits;
    logic        req_valid;
    logic [6:0]  req_bits;
    logic        req_rdy;
    logic        stall;
    logic [63:0] data_out;
    logic        out_valid;
    logic        error;
    logic        done;

    int passCount;
    int checkCount;

    shift_split dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_rdy    (in_rdy),
        .msg_fin   (msg_fin),
        .last_bits (last_bits),
        .req_valid (req_valid),
        .req_bits  (req_bits),
        .req_rdy   (req_rdy),
        .stall     (stall),
        .data_out  (data_out),
        .out_valid (out_valid),
        .error     (error),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic iv, input logic [63:0] d, input logic fin,
                                 input logic [6:0] lb, input logic rv, input logic [6:0] rb,
                                 input logic st);
        in_valid  = iv;
        data_in   = d;
        msg_fin   = fin;
        last_bits = lb;
        req_valid = rv;
        req_bits  = rb;
        stall     = st;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Advance one clock and land just after the edge, where registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst = 1'b0;
        applyStimulus(1'b1, 64'hDEAD_BEEF_0000_1111, 1'b1, 7'd5, 1'b1, 7'd4, 1'b0);
        #3;
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_in_rdy", in_rdy, 1);
        checkOutput("rst_req_rdy", req_rdy, 0);
        #4;
        rst = 1'b1;

        // Basic unpack of a single word into 4/8/52-bit chunks.
        applyStimulus(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd4, 1'b0);
        #1;
        checkOutput("basic_req_rdy", req_rdy, 1);
        tick();
        checkOutput("basic_c4_valid", out_valid, 1);
        checkOutput("basic_c4", data_out, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd8, 1'b0);
        tick();
        checkOutput("basic_c8", data_out, 64'h12);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd52, 1'b0);
        tick();
        checkOutput("basic_c52", data_out, 64'h3_4567_89AB_CDEF);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();
        checkOutput("basic_pulse_end", out_valid, 0);
        checkOutput("basic_fill", dut.fill_q, 0);

        // Word-boundary straddle plus stall behaviour.
        applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd60, 1'b0);
        #1;
        checkOutput("strad_full_in_rdy", in_rdy, 0);
        tick();
        checkOutput("strad_c60", data_out, 64'h0FFF_FFFF_FFFF_FFFF);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd8, 1'b0);
        tick();
        checkOutput("strad_c8", data_out, 64'hF0);
        checkOutput("strad_fill", dut.fill_q, 60);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd60, 1'b1);
        #1;
        checkOutput("stall_req_rdy", req_rdy, 0);
        tick();
        checkOutput("stall_out_valid", out_valid, 0);
        checkOutput("stall_error", error, 0);
        checkOutput("stall_fill", dut.fill_q, 60);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd60, 1'b0);
        tick();
        checkOutput("strad_drain", data_out, 64'h0);
        checkOutput("strad_drain_fill", dut.fill_q, 0);

        // Bad lengths are rejected; a short request before end of message just waits.
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd0, 1'b0);
        tick();
        checkOutput("err_len0", error, 1);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd65, 1'b0);
        tick();
        checkOutput("err_len65", error, 1);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd8, 1'b0);
        tick();
        checkOutput("wait_no_error", error, 0);
        checkOutput("wait_no_valid", out_valid, 0);

        // End of message: 12 valid bits, drained exactly.
        applyStimulus(1'b1, 64'hABC0_0000_0000_0000, 1'b1, 7'd12, 1'b0, 7'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd12, 1'b0);
        #1;
        checkOutput("eom_in_rdy_low", in_rdy, 0);
        tick();
        checkOutput("eom_chunk", data_out, 64'hABC);
        checkOutput("eom_done", done, 1);
        checkOutput("eom_in_rdy_back", in_rdy, 1);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();
        checkOutput("eom_done_pulse", done, 0);

        // Over-request at end of message.
        applyStimulus(1'b1, 64'h5A00_0000_0000_0000, 1'b1, 7'd8, 1'b0, 7'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd16, 1'b0);
        tick();
`ifdef SPLIT_ZERO_PAD_EN
        checkOutput("over_pad_valid", out_valid, 1);
        checkOutput("over_pad_chunk", data_out, 64'h5A00);
        checkOutput("over_pad_error", error, 0);
        checkOutput("over_pad_done", done, 1);
`else
        checkOutput("over_error", error, 1);
        checkOutput("over_no_valid", out_valid, 0);
        checkOutput("over_fill", dut.fill_q, 8);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd8, 1'b0);
        tick();
        checkOutput("over_tail", data_out, 64'h5A);
        checkOutput("over_done", done, 1);
`endif
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();

        // Reset in the middle of a message with 100 bits buffered.
        applyStimulus(1'b1, 64'h1111_1111_1111_1111, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 64'h2222_2222_2222_2222, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd28, 1'b0);
        tick();
        checkOutput("mid_fill100", dut.fill_q, 100);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        rst = 1'b0;
        #2;
        checkOutput("mid_rst_fill", dut.fill_q, 0);
        checkOutput("mid_rst_in_rdy", in_rdy, 1);
        checkOutput("mid_rst_done", done, 0);
        #2;
        rst = 1'b1;
        tick();
        checkOutput("mid_post_done", done, 0);
        checkOutput("mid_post_error", error, 0);
        applyStimulus(1'b1, 64'h8000_0000_0000_0001, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd1, 1'b0);
        tick();
        checkOutput("mid_first_bit", data_out, 64'h1);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b1, 7'd63, 1'b0);
        tick();
        checkOutput("mid_rest", data_out, 64'h1);
        applyStimulus(1'b0, 64'h0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/shift_split.md
# shift_split

Bit-stream unpacker for the receive/decode path of the data-stream encryption/compression device. It accepts 64-bit packed words, the form a concatenating packer produces, and returns variable-length chunks of 1..64 bits on request. These chunks feed the decompressor. It tracks the message boundary signalled with the final word, reports when the message has been fully drained, and flags requests that cannot be served.

## Interface
- WORD_W, 64, packed word and maximum chunk width
- CNT_W, 7, width of bit-count fields

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- data_in  in  WORD_W  packed word; first bit of the stream is bit 63
- in_valid  in  1  data_in valid
- in_rdy  out  1  word accepted when in_valid && in_rdy
- msg_fin  in  1  qualifies data_in as the last word of the message
- last_bits  in  CNT_W  valid bits in the final word, MSB-aligned; 1..64, 0 means 64
- req_valid  in  1  chunk request
- req_bits  in  CNT_W  requested chunk length, 1..64
- req_rdy  out  1  request served this cycle when req_valid && req_rdy
- stall  in  1  downstream stall; blocks request service
- data_out  out  WORD_W  chunk, right-aligned, unused upper bits zero
- out_valid  out  1  one-cycle pulse, data_out valid
- error  out  1  one-cycle pulse, request rejected
- done  out  1  one-cycle pulse, message fully drained

## Operation
- State:
  - 128-bit buffer `buf`, MSB-first.
  - `fill` (0..128, 8 bits).
  - `fin_seen` flag.
- `in_rdy` = (fill <= 64) && !fin_seen. It is combinational from registers only.
- Word accept:
  - The word is appended directly below the current valid bits.
  - `fill` grows by 64, or by last_bits (0 meaning 64) when msg_fin is set.
  - msg_fin sets fin_seen.
- `req_rdy` = !stall && 1 <= req_bits <= 64 && fill >= req_bits. It is combinational.
- Serve:
  - data_out <= top req_bits bits of buf, right-aligned.
  - buf shifts left by req_bits and fill decreases by req_bits.
  - out_valid pulses.
- Simultaneous accept and serve: the shift is applied first, then the append at the new fill.
  - fill_next = fill - req_bits + appended.
  - This never exceeds 128.
- Error (pulse, nothing consumed, buffer unchanged), raised when req_valid && !stall and either:
  - req_bits is 0 or greater than 64, or
  - fin_seen && req_bits > fill.
- A request with !fin_seen and insufficient fill simply waits. It is not an error.
- Drain: when fin_seen and fill reaches 0, done pulses and fin_seen clears. in_rdy reasserts in the same cycle done is high.
- Stall:
  - Requests are blocked and no error is raised.
  - Word accept continues.
  - out_valid is never held longer than one cycle.

## Timing
- Reset values:
  - data_out=0, out_valid=0, error=0, done=0.
  - fill=0, fin_seen=0, buf=0.
  - Hence in_rdy=1 and req_rdy=0.
- A word accepted in cycle N is servable from cycle N+1.
- A request served in cycle N gives data_out/out_valid in cycle N+1.
- error is asserted in cycle N+1 for a request rejected in N.
- done is asserted in the cycle after the serve that empties the buffer.
- Throughput: one chunk per cycle. One word per cycle while fill <= 64.
- Reset asserted mid-message:
  - All state clears immediately.
  - No done or error pulse is produced.
  - Partial data is discarded.

## Configuration
- `SPLIT_ZERO_PAD_EN` defined:
  - A request with fin_seen && req_bits > fill (fill > 0) is served, not rejected.
  - The remaining bits are placed at the top of the req_bits-wide chunk and zero-padded below.
  - fill becomes 0, out_valid pulses, no error is raised, and done follows.
- `SPLIT_ZERO_PAD_EN` undefined: that request raises error as above.

## Test plan
- Reset: rst=0 with any inputs -> data_out=0, out_valid=0, error=0, done=0, in_rdy=1, req_rdy=0.
- Word 64'h0123_4567_89AB_CDEF, then requests of 4, 8 and 52 bits -> data_out 0x0, 0x12 and 0x3456789ABCDEF on consecutive cycles.
- Word-boundary straddle:
  - Stimulus: words 64'hFFFF_FFFF_FFFF_FFFF then 0; requests 60, then 8.
  - Required response: second chunk 0xF0, fill=60.
- End of message:
  - Stimulus: msg_fin=1, last_bits=12, data_in=64'hABC0_0000_0000_0000; request 12.
  - Required response: data_out=0xABC; done pulses one cycle later; in_rdy returns to 1.
- End over-request:
  - Stimulus: last_bits=8, data_in=64'h5A00_..._0; request 16.
  - Without the macro: error pulse, fill stays 8.
  - With the macro: data_out=16'h5A00, then done.
- Reset mid-operation with fill=100 -> fill=0, no done pulse, in_rdy=1, and the next word is unpacked from its bit 63.
